// File: rtl/grad_descent_ctrl.sv
// Iteration controller for the 4D gradient-descent datapath: issues gradient
// requests, applies saturated steps and stops on convergence/limit/fault.
module grad_descent_ctrl #(
  parameter logic [15:0] MAX_ITER     = 16'd256,
  parameter logic [15:0] TOLERANCE    = 16'h0002,
  parameter logic [15:0] WAIT_TIMEOUT = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] a_init,
  input  logic [15:0] b_init,
  input  logic [15:0] c_init,
  input  logic [15:0] d_init,
  output logic        grad_start,
  output logic [15:0] a_cur,
  output logic [15:0] b_cur,
  output logic [15:0] c_cur,
  output logic [15:0] d_cur,
  input  logic [31:0] grad_value,
  input  logic [15:0] a_diff,
  input  logic [15:0] b_diff,
  input  logic [15:0] c_diff,
  input  logic [15:0] d_diff,
  input  logic        grad_done,
  input  logic        grad_overflow,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [15:0] iter_count,
  output logic [31:0] value_out
);

  localparam int unsigned DW = 16;
  localparam int unsigned VW = 32;
  localparam int unsigned SW = 2;

  localparam logic [SW-1:0] ST_CONVERGED = 2'b00;
  localparam logic [SW-1:0] ST_MAX_ITER  = 2'b01;
  localparam logic [SW-1:0] ST_OVERFLOW  = 2'b10;
  localparam logic [SW-1:0] ST_ABORT     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [DW-1:0] da_q, da_d, db_q, db_d, dc_q, dc_d, dd_q, dd_d;
  logic [DW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] iter_q, iter_d;
  logic [VW-1:0] value_q, value_d;
  logic [SW-1:0] status_q, status_d;
  logic          grad_start_q, grad_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          converged_c;
  logic          run_state_c;

  // 17-bit signed x - d, clamped to the Q8.8 range.
  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] x,
                                            input logic [DW-1:0] d);
    logic [DW:0] r;
    r = {x[DW-1], x} - {d[DW-1], d};
    if (r[DW] != r[DW-1]) begin
      sat_sub = r[DW] ? 16'h8000 : 16'h7FFF;
    end else begin
      sat_sub = r[DW-1:0];
    end
  endfunction

  // Magnitude kept at 17 bits so that |0x8000| does not wrap.
  function automatic logic [DW:0] mag17(input logic [DW-1:0] d);
    logic [DW:0] ext;
    ext = {d[DW-1], d};
    mag17 = d[DW-1] ? ((DW+1)'(0) - ext) : ext;
  endfunction

  assign converged_c = (mag17(da_q) <= {1'b0, TOLERANCE}) &&
                       (mag17(db_q) <= {1'b0, TOLERANCE}) &&
                       (mag17(dc_q) <= {1'b0, TOLERANCE}) &&
                       (mag17(dd_q) <= {1'b0, TOLERANCE});

  assign run_state_c = (state_q != S_IDLE) && (state_q != S_DONE);

  // Next-state and register update logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    da_d     = da_q;
    db_d     = db_q;
    dc_d     = dc_q;
    dd_d     = dd_q;
    tmo_d    = tmo_q;
    iter_d   = iter_q;
    value_d  = value_q;
    status_d = status_q;

    if (abort && run_state_c) begin
      status_d = ST_ABORT;
      state_d  = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_d = S_LOAD;
        end
        S_LOAD: begin
          a_d      = a_init;
          b_d      = b_init;
          c_d      = c_init;
          d_d      = d_init;
          iter_d   = '0;
          status_d = ST_CONVERGED;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          tmo_d = tmo_q + DW'(1);
          if (grad_done) begin
            if (grad_overflow) begin
              status_d = ST_OVERFLOW;
              state_d  = S_DONE;
            end else begin
              da_d    = a_diff;
              db_d    = b_diff;
              dc_d    = c_diff;
              dd_d    = d_diff;
              value_d = grad_value;
              state_d = S_UPDATE;
            end
          end else if ((tmo_q + DW'(1)) == WAIT_TIMEOUT) begin
            status_d = ST_ABORT;
            state_d  = S_DONE;
          end
        end
        S_UPDATE: begin
          a_d     = sat_sub(a_q, da_q);
          b_d     = sat_sub(b_q, db_q);
          c_d     = sat_sub(c_q, dc_q);
          d_d     = sat_sub(d_q, dd_q);
          iter_d  = iter_q + DW'(1);
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (converged_c) begin
            status_d = ST_CONVERGED;
            state_d  = S_DONE;
          end else if (iter_q == MAX_ITER) begin
            status_d = ST_MAX_ITER;
            state_d  = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Strobes are registered so they line up with the state they describe.
    grad_start_d = (state_d == S_ISSUE);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      d_q          <= '0;
      da_q         <= '0;
      db_q         <= '0;
      dc_q         <= '0;
      dd_q         <= '0;
      tmo_q        <= '0;
      iter_q       <= '0;
      value_q      <= '0;
      status_q     <= '0;
      grad_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      c_q          <= c_d;
      d_q          <= d_d;
      da_q         <= da_d;
      db_q         <= db_d;
      dc_q         <= dc_d;
      dd_q         <= dd_d;
      tmo_q        <= tmo_d;
      iter_q       <= iter_d;
      value_q      <= value_d;
      status_q     <= status_d;
      grad_start_q <= grad_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign grad_start = grad_start_q;
  assign a_cur      = a_q;
  assign b_cur      = b_q;
  assign c_cur      = c_q;
  assign d_cur      = d_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign iter_count = iter_q;
  assign value_out  = value_q;

endmodule

// File: tb/tb_grad_descent_ctrl.sv
// Scoreboard bench for grad_descent_ctrl with a behavioural gradient block.
module tb_grad_descent_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] a_init, b_init, c_init, d_init;
  logic        grad_start;
  logic [15:0] a_cur, b_cur, c_cur, d_cur;
  logic [31:0] grad_value;
  logic [15:0] a_diff, b_diff, c_diff, d_diff;
  logic        grad_done, grad_overflow;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] iter_count;
  logic [31:0] value_out;

  grad_descent_ctrl #(
    .MAX_ITER(16'd4),
    .TOLERANCE(16'h0002),
    .WAIT_TIMEOUT(16'd16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_init(a_init), .b_init(b_init), .c_init(c_init), .d_init(d_init),
    .grad_start(grad_start),
    .a_cur(a_cur), .b_cur(b_cur), .c_cur(c_cur), .d_cur(d_cur),
    .grad_value(grad_value),
    .a_diff(a_diff), .b_diff(b_diff), .c_diff(c_diff), .d_diff(d_diff),
    .grad_done(grad_done), .grad_overflow(grad_overflow),
    .busy(busy), .done(done), .status(status),
    .iter_count(iter_count), .value_out(value_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  status;
    logic [15:0] iter;
    logic [15:0] a, b, c, d;
    logic [31:0] value;
    int          starts;
    int          gap;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gs_cyc = 0;
  int   starts_seen = 0;
  int   done_cnt = 0;
  bit   prev_done = 1'b0;

  logic [15:0] m_da, m_db, m_dc, m_dd;
  int          m_ovf_idx = -1;
  bit          m_noresp = 1'b0;
  int          resp_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Gradient block model: answers two cycles after each request.
  initial forever begin
    @(negedge clk);
    if (grad_start && !m_noresp) begin
      int idx;
      idx = resp_idx;
      resp_idx++;
      repeat (2) @(negedge clk);
      a_diff        = m_da;
      b_diff        = m_db;
      c_diff        = m_dc;
      d_diff        = m_dd;
      grad_value    = 32'h0000_1000 + 32'(idx);
      grad_overflow = (idx == m_ovf_idx);
      grad_done     = 1'b1;
      @(negedge clk);
      grad_done     = 1'b0;
      grad_overflow = 1'b0;
    end
  end

  // Monitor: pops an expectation on every done pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (prev_done) chk("done_single_cycle", 32'(done), 32'd0);
    prev_done = done;
    if (grad_start) begin
      gs_cyc = cyc;
      starts_seen++;
    end
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("status", 32'(status), 32'(e.status));
        chk("iter_count", 32'(iter_count), 32'(e.iter));
        chk("a_cur", 32'(a_cur), 32'(e.a));
        chk("b_cur", 32'(b_cur), 32'(e.b));
        chk("c_cur", 32'(c_cur), 32'(e.c));
        chk("d_cur", 32'(d_cur), 32'(e.d));
        chk("value_out", value_out, e.value);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("grad_starts", 32'(starts_seen), 32'(e.starts));
        if (e.gap >= 0) chk("done_latency", 32'(cyc - gs_cyc), 32'(e.gap));
      end
      starts_seen = 0;
    end
  end

  task automatic run(input logic [15:0] ia, ib, ic, id, da, db, dc, dd,
                     input int ovf, input bit noresp, input int abort_after,
                     input bit poke_start, input exp_t e);
    int d0;
    bit got;
    m_da = da; m_db = db; m_dc = dc; m_dd = dd;
    m_ovf_idx = ovf;
    m_noresp  = noresp;
    resp_idx  = 0;
    sbq.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    a_init = ia; b_init = ib; c_init = ic; d_init = id;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (abort_after > 0 || poke_start) begin
      for (int i = 0; i < 10 && !grad_start; i++) @(negedge clk);
      if (abort_after > 0) begin
        repeat (abort_after) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      if (poke_start) begin
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (done_cnt != d0);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL run_done_wait actual=no_done expected=done at cycle %0d", cyc);
      void'(sbq.pop_back());
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    a_init = '0; b_init = '0; c_init = '0; d_init = '0;
    grad_value = '0; grad_done = 1'b0; grad_overflow = 1'b0;
    a_diff = '0; b_diff = '0; c_diff = '0; d_diff = '0;
    m_da = '0; m_db = '0; m_dc = '0; m_dd = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grad_start", 32'(grad_start), 32'd0);
    chk("rst_a_cur", 32'(a_cur), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Converge after one step.
    e = '{2'b00, 16'd1, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 32'h1000, 1, -1};
    run(16'h0100, 16'h0100, 16'h0100, 16'h0100,
        16'h0001, 16'h0001, 16'h0001, 16'h0001, -1, 1'b0, 0, 1'b0, e);

    // Iteration limit of 4.
    e = '{2'b01, 16'd4, 16'h00C0, 16'h00C0, 16'h00C0, 16'h00C0, 32'h1003, 4, -1};
    run(16'h0100, 16'h0100, 16'h0100, 16'h0100,
        16'h0010, 16'h0010, 16'h0010, 16'h0010, -1, 1'b0, 0, 1'b0, e);

    // Saturation at both rails; |0x8000| must not read as converged.
    e = '{2'b01, 16'd4, 16'h8000, 16'h7FFF, 16'h7FFF, 16'hFFFC, 32'h1003, 4, -1};
    run(16'h8010, 16'h7FF0, 16'h0000, 16'h0000,
        16'h0020, 16'hFFE0, 16'h8000, 16'h0001, -1, 1'b0, 0, 1'b0, e);

    // Overflow on the second iteration.
    e = '{2'b10, 16'd1, 16'h00F0, 16'h00F0, 16'h00F0, 16'h00F0, 32'h1000, 2, -1};
    run(16'h0100, 16'h0100, 16'h0100, 16'h0100,
        16'h0010, 16'h0010, 16'h0010, 16'h0010, 1, 1'b0, 0, 1'b0, e);

    // Timeout with a stray start mid-run.
    e = '{2'b11, 16'd0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h1000, 1, 17};
    run(16'h0100, 16'h0100, 16'h0100, 16'h0100,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, 1'b1, 0, 1'b1, e);
    repeat (10) @(negedge clk);
    chk("start_while_busy_ignored", 32'(busy), 32'd0);

    // Abort during WAIT.
    e = '{2'b11, 16'd0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h1000, 1, 3};
    run(16'h0100, 16'h0100, 16'h0100, 16'h0100,
        16'h0000, 16'h0000, 16'h0000, 16'h0000, -1, 1'b1, 2, 1'b0, e);

    // Asynchronous reset in the middle of WAIT.
    m_noresp = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_grad_start", 32'(grad_start), 32'd0);
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_iter", 32'(iter_count), 32'd0);
    chk("arst_value", value_out, 32'd0);
    chk("arst_cur", {a_cur | b_cur, c_cur | d_cur}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {30'd0, grad_start, busy}, 32'd0);
    end

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
